// File: rtl/bus2_line_master.sv
// bus2_line_master: cache-side master on the shared bus-2 (A2/D2/C2).
// Takes one line request at a time from the cache core. A write line is serialised into
// 16-bit beats, low byte first. A read sends the command and then reassembles the memory
// controller's response beats into a full line. The block owns the cache-side bus direction
// and turnaround: it drives the buses only in W_DATA and R_CMD.
// Optional feature: define BUS2_TIMEOUT_EN to bound the wait for C2_RESPONSE to
// BUS2_TIMEOUT_CYCLES cycles. A timeout ends the transfer with done=1 and err=1.
module bus2_line_master #(
  parameter int unsigned ADDR2_BUS_SIZE  = 14,
  parameter int unsigned DATA2_BUS_SIZE  = 16,
  parameter int unsigned CTR2_BUS_SIZE   = 2,
  parameter int unsigned CACHE_LINE_SIZE = 16
`ifdef BUS2_TIMEOUT_EN
  ,
  parameter int unsigned BUS2_TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]      req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]   req_wdata,
  output logic                           done,
  output logic [CACHE_LINE_SIZE*8-1:0]   rd_data,
  output logic                           err,
  inout  wire  [ADDR2_BUS_SIZE-1:0]      A2_WIRE,
  inout  wire  [DATA2_BUS_SIZE-1:0]      D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]       C2_WIRE
);

  localparam int unsigned LineW    = CACHE_LINE_SIZE * 8;
  localparam int unsigned Beats    = LineW / DATA2_BUS_SIZE;
  localparam int unsigned CntW     = $clog2(Beats);
  localparam int unsigned DataLsbW = $clog2(DATA2_BUS_SIZE);
  localparam int unsigned LineIdxW = $clog2(LineW);

  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

`ifdef BUS2_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(BUS2_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWData,
    StWWait,
    StRCmd,
    StRWait,
    StRData
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  // Holds the write line during W_DATA and assembles the read line during R_DATA.
  logic [LineW-1:0]          line_q, line_d;
  logic [LineW-1:0]          rd_data_q, rd_data_d;
  logic                      done_q, done_d;
  // Set for the first R_WAIT cycle, the bus turnaround, when C2 is not trusted.
  logic                      ta_q, ta_d;
`ifdef BUS2_TIMEOUT_EN
  logic [7:0]                wait_q, wait_d;
  logic                      err_q, err_d;
`endif

  logic [LineIdxW-1:0]       beat_lsb;
  logic                      resp;

  logic                      a2_oe, d2_oe, c2_oe;
  logic [ADDR2_BUS_SIZE-1:0] a2_out;
  logic [DATA2_BUS_SIZE-1:0] d2_out;
  logic [CTR2_BUS_SIZE-1:0]  c2_out;

  assign beat_lsb = {cnt_q, {DataLsbW{1'b0}}};
  assign resp     = (C2_WIRE == C2_RESPONSE);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: beat counter, latched request, line buffer and result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      ta_q      <= 1'b0;
`ifdef BUS2_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      ta_q      <= ta_d;
`ifdef BUS2_TIMEOUT_EN
      wait_q    <= wait_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    line_d    = line_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    ta_d      = ta_q;
`ifdef BUS2_TIMEOUT_EN
    wait_d    = wait_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          line_d  = req_wdata;
          cnt_d   = '0;
          ta_d    = 1'b0;
`ifdef BUS2_TIMEOUT_EN
          wait_d  = '0;
`endif
          state_d = req_write ? StWData : StRCmd;
        end
      end
      StWData: begin
        cnt_d = cnt_q + 1'b1;
        // Only the counter wrap ends the burst.
        if (cnt_q == LastBeat) begin
          state_d = StWWait;
        end
      end
      StWWait: begin
        if (resp) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
`ifdef BUS2_TIMEOUT_EN
        else if (wait_q == TimeoutLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      StRCmd: begin
        ta_d    = 1'b1;
        state_d = StRWait;
      end
      StRWait: begin
        if (ta_q) begin
          ta_d = 1'b0;
        end else if (resp) begin
          // The response cycle already carries beat 0.
          line_d[beat_lsb +: DATA2_BUS_SIZE] = D2_WIRE;
          cnt_d   = cnt_q + 1'b1;
          state_d = StRData;
        end
`ifdef BUS2_TIMEOUT_EN
        else if (wait_q == TimeoutLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      StRData: begin
        line_d[beat_lsb +: DATA2_BUS_SIZE] = D2_WIRE;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBeat) begin
          rd_data_d = line_d;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: request handshake and bus drive enables.
  always_comb begin
    req_ready = (state_q == StIdle);
    a2_oe     = 1'b0;
    d2_oe     = 1'b0;
    c2_oe     = 1'b0;
    a2_out    = addr_q;
    d2_out    = line_q[beat_lsb +: DATA2_BUS_SIZE];
    c2_out    = C2_NOP;
    unique case (state_q)
      StWData: begin
        c2_oe  = 1'b1;
        d2_oe  = 1'b1;
        a2_oe  = (cnt_q == '0);
        c2_out = (cnt_q == '0) ? C2_WRITE_LINE : C2_NOP;
      end
      StRCmd: begin
        c2_oe  = 1'b1;
        a2_oe  = 1'b1;
        c2_out = C2_READ_LINE;
      end
      default: begin
      end
    endcase
  end

  assign A2_WIRE = a2_oe ? a2_out : 'z;
  assign D2_WIRE = d2_oe ? d2_out : 'z;
  assign C2_WIRE = c2_oe ? c2_out : 'z;

  assign done    = done_q;
  assign rd_data = rd_data_q;
`ifdef BUS2_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus2_line_master.sv
// Directed bench for bus2_line_master. The bench plays the memory controller on bus 2.
// While the master should have released a bus, the bench drives zeros onto it as a keeper,
// so any stray drive from the master shows up as a non-zero read.
module tb_bus2_line_master;

  logic         CLK;
  logic         RESET;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [13:0]  req_addr;
  logic [127:0] req_wdata;
  logic         done;
  logic [127:0] rd_data;
  logic         err;

  wire  [13:0]  a2_w;
  wire  [15:0]  d2_w;
  wire  [1:0]   c2_w;

  logic         a2_oe;
  logic         c2_oe;
  logic         d2_oe;
  logic [1:0]   c2_drv;
  logic [15:0]  d2_drv;

  int checks   = 0;
  int failures = 0;

  assign a2_w = a2_oe ? 14'h0 : 'z;
  assign c2_w = c2_oe ? c2_drv : 'z;
  assign d2_w = d2_oe ? d2_drv : 'z;

  bus2_line_master #(
    .ADDR2_BUS_SIZE(14)
`ifdef BUS2_TIMEOUT_EN
    ,
    .BUS2_TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rd_data   (rd_data),
    .err       (err),
    .A2_WIRE   (a2_w),
    .D2_WIRE   (d2_w),
    .C2_WIRE   (c2_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line with byte k = base + k.
  function automatic logic [127:0] mk_line(input logic [7:0] base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  task automatic test_reset();
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    a2_oe = 1'b1; c2_oe = 1'b1; d2_oe = 1'b1; c2_drv = 2'd0; d2_drv = 16'h0;
    repeat (2) @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err); end
    checks++; if (rd_data !== 128'h0) begin failures++; $display("FAIL rst_rd_data got=%h want=0", rd_data); end
    checks++; if (a2_w !== 14'h0 || d2_w !== 16'h0 || c2_w !== 2'd0) begin
      failures++; $display("FAIL rst_bus_released got a2=%h d2=%h c2=%h want 0", a2_w, d2_w, c2_w);
    end
    RESET = 1'b1;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_write();
    logic [15:0] exp;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0012; req_wdata = mk_line(8'hA0);
    a2_oe = 1'b0; c2_oe = 1'b0; d2_oe = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {8'hA0 + 8'(2*i+1), 8'hA0 + 8'(2*i)};
      checks++; if (d2_w !== exp) begin failures++; $display("FAIL wr_d2 beat%0d got=%h want=%h", i, d2_w, exp); end
      checks++; if (c2_w !== (i == 0 ? 2'd3 : 2'd0)) begin failures++; $display("FAIL wr_c2 beat%0d got=%0d", i, c2_w); end
      checks++; if (a2_w !== (i == 0 ? 14'h0012 : 14'h0)) begin failures++; $display("FAIL wr_a2 beat%0d got=%h", i, a2_w); end
      checks++; if (req_ready !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL wr_busy beat%0d got ready=%b done=%b want 0 0", i, req_ready, done);
      end
      a2_oe = 1'b1;
      if (i == 7) begin c2_oe = 1'b1; d2_oe = 1'b1; end
      @(negedge CLK);
    end
    for (int j = 0; j < 4; j++) begin
      checks++; if (a2_w !== 14'h0 || d2_w !== 16'h0 || c2_w !== 2'd0 || done !== 1'b0) begin
        failures++; $display("FAIL wr_wait%0d got a2=%h d2=%h c2=%h done=%b want 0", j, a2_w, d2_w, c2_w, done);
      end
      @(negedge CLK);
    end
    c2_drv = 2'd1;
    @(negedge CLK);
    c2_drv = 2'd0;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wr_done got done=%b err=%b want 1 0", done, err); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b want=1", req_ready); end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL wr_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0003;
    a2_oe = 1'b0; c2_oe = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    checks++; if (c2_w !== 2'd2 || a2_w !== 14'h0003 || d2_w !== 16'h0) begin
      failures++; $display("FAIL rd_cmd got c2=%0d a2=%h d2=%h want 2 0003 0", c2_w, a2_w, d2_w);
    end
    a2_oe = 1'b1; c2_oe = 1'b1;
    @(negedge CLK);
    checks++; if (c2_w !== 2'd0 || a2_w !== 14'h0 || done !== 1'b0) begin
      failures++; $display("FAIL rd_release got c2=%0d a2=%h done=%b want 0", c2_w, a2_w, done);
    end
    @(negedge CLK);
    c2_drv = 2'd1; d2_drv = 16'h0100;
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rd_early_done beat%0d got=%b want=0", i, done); end
      c2_drv = 2'd0; d2_drv = {8'(2*i+1), 8'(2*i)};
    end
    @(negedge CLK);
    d2_drv = 16'h0;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL rd_done got done=%b err=%b want 1 0", done, err); end
    checks++; if (rd_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failures++; $display("FAIL rd_data got=%h want=0f0e0d0c0b0a09080706050403020100", rd_data);
    end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b want=1", req_ready); end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rd_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_read_turnaround();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0005;
    a2_oe = 1'b0; c2_oe = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    checks++; if (c2_w !== 2'd2 || a2_w !== 14'h0005) begin
      failures++; $display("FAIL ta_cmd got c2=%0d a2=%h want 2 0005", c2_w, a2_w);
    end
    a2_oe = 1'b1; c2_oe = 1'b1;
    @(negedge CLK);
    // RESPONSE during the turnaround cycle must be ignored.
    c2_drv = 2'd1; d2_drv = 16'hDEAD;
    @(negedge CLK);
    c2_drv = 2'd0; d2_drv = 16'h0;
    @(negedge CLK);
    checks++; if (done !== 1'b0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL ta_ignored got done=%b ready=%b want 0 0", done, req_ready);
    end
    // A non-RESPONSE code while waiting must be ignored too.
    c2_drv = 2'd3; d2_drv = 16'hBEEF;
    @(negedge CLK);
    c2_drv = 2'd1; d2_drv = 16'h1110;
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      checks++; if (done !== 1'b0 || req_ready !== 1'b0) begin
        failures++; $display("FAIL ta_busy beat%0d got done=%b ready=%b want 0 0", i, done, req_ready);
      end
      c2_drv = 2'd0; d2_drv = {8'h10 + 8'(2*i+1), 8'h10 + 8'(2*i)};
    end
    @(negedge CLK);
    d2_drv = 16'h0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ta_done got=%b want=1", done); end
    checks++; if (rd_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      failures++; $display("FAIL ta_rd_data got=%h want=1f1e1d1c1b1a19181716151413121110", rd_data);
    end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ta_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  base;
    logic [13:0] addr;
    logic [15:0] exp;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0100; req_wdata = mk_line(8'h20);
    a2_oe = 1'b0; c2_oe = 1'b0; d2_oe = 1'b0;
    @(negedge CLK);
    for (int b = 0; b < 2; b++) begin
      base = (b == 0) ? 8'h20 : 8'h60;
      addr = (b == 0) ? 14'h0100 : 14'h0200;
      if (b == 0) begin req_addr = 14'h0200; req_wdata = mk_line(8'h60); end
      for (int i = 0; i < 8; i++) begin
        exp = {base + 8'(2*i+1), base + 8'(2*i)};
        checks++; if (d2_w !== exp) begin failures++; $display("FAIL b2b%0d_d2 beat%0d got=%h want=%h", b, i, d2_w, exp); end
        checks++; if (c2_w !== (i == 0 ? 2'd3 : 2'd0) || a2_w !== (i == 0 ? addr : 14'h0)) begin
          failures++; $display("FAIL b2b%0d_ctl beat%0d got c2=%0d a2=%h", b, i, c2_w, a2_w);
        end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b%0d_done beat%0d got=%b want=0", b, i, done); end
        a2_oe = 1'b1;
        if (i == 7) begin c2_oe = 1'b1; d2_oe = 1'b1; end
        @(negedge CLK);
      end
      c2_drv = 2'd1;
      @(negedge CLK);
      c2_drv = 2'd0;
      checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin
        failures++; $display("FAIL b2b%0d_done got done=%b ready=%b want 1 1", b, done, req_ready);
      end
      if (b == 0) begin
        a2_oe = 1'b0; c2_oe = 1'b0; d2_oe = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge CLK);
    end
    checks++; if (done !== 1'b0 || req_ready !== 1'b1 || c2_w !== 2'd0 || d2_w !== 16'h0) begin
      failures++; $display("FAIL b2b_end got done=%b ready=%b c2=%0d d2=%h", done, req_ready, c2_w, d2_w);
    end
  endtask

`ifdef BUS2_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0007;
    a2_oe = 1'b0; c2_oe = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    a2_oe = 1'b1; c2_oe = 1'b1; c2_drv = 2'd0;
    for (int j = 1; j < 12; j++) begin
      @(negedge CLK);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL to_early cyc%0d got done=%b want=0", j, done); end
    end
    @(negedge CLK);
    checks++; if (done !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL to_done got done=%b err=%b want 1 1", done, err); end
    checks++; if (rd_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      failures++; $display("FAIL to_rd_data got=%h want=1f1e1d1c1b1a19181716151413121110", rd_data);
    end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_ready got=%b want=1", req_ready); end
    @(negedge CLK);
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL to_pulse got done=%b err=%b want 0 0", done, err); end
  endtask
`endif

  task automatic test_reset_mid_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0033; req_wdata = mk_line(8'h40);
    a2_oe = 1'b0; c2_oe = 1'b0; d2_oe = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    a2_oe = 1'b1;
    repeat (4) @(negedge CLK);
    checks++; if (d2_w !== 16'h4948) begin failures++; $display("FAIL mid_beat4 got=%h want=4948", d2_w); end
    RESET = 1'b0;
    c2_oe = 1'b1; d2_oe = 1'b1;
    #1;
    checks++; if (a2_w !== 14'h0 || d2_w !== 16'h0 || c2_w !== 2'd0) begin
      failures++; $display("FAIL mid_bus_z got a2=%h d2=%h c2=%h want 0", a2_w, d2_w, c2_w);
    end
    checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL mid_ctl got ready=%b done=%b want 1 0", req_ready, done);
    end
    checks++; if (rd_data !== 128'h0) begin failures++; $display("FAIL mid_rd_data got=%h want=0", rd_data); end
    @(negedge CLK);
    RESET = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      checks++; if (done !== 1'b0 || req_ready !== 1'b1 || c2_w !== 2'd0 || d2_w !== 16'h0) begin
        failures++; $display("FAIL mid_after%0d got done=%b ready=%b c2=%0d d2=%h", j, done, req_ready, c2_w, d2_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_turnaround();
    test_back_to_back();
`ifdef BUS2_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
